cpu_fetch_unit: RTL and testbench
=================================

Name: cpu_fetch_unit

Overview:
- Instruction-fetch sequencer directly downstream of the 8-phase CPU clock generator.
- Consumes the one-hot, one-cycle phase strobes clock_1..clock_8 and runs one fetch per 8-phase frame.
- Maintains the PC, issues a synchronous instruction-memory read, latches the instruction register and exposes decoded fields to the execute logic.
- Supports PC load (branch/jump) and a halt/resume handshake.

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- DATA_W, 16, instruction width.
- OPCODE_W, 4, opcode field width (MSBs of ir).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- clock_1..clock_8  in  1 each  phase strobes from the clock generator; at most one high per cycle.
- imem_addr  out  ADDR_W  instruction-memory address.
- imem_rd  out  1  memory read strobe.
- imem_rdata  in  DATA_W  memory read data; valid in the cycle after imem_rd is high.
- pc_load  in  1  load PC from pc_load_value; sampled only in phase 7.
- pc_load_value  in  ADDR_W  branch/jump target.
- halt_req  in  1  halt request; sampled only in phase 8.
- resume  in  1  leave HALTED; sampled any cycle.
- pc  out  ADDR_W  current program counter.
- ir  out  DATA_W  instruction register.
- ir_valid  out  1  one-cycle pulse: ir was just updated.
- opcode  out  OPCODE_W  ir[DATA_W-1 -: OPCODE_W], combinational.
- operand  out  DATA_W-OPCODE_W  remaining ir bits, combinational.
- halted  out  1  high while in HALTED.
- phase_err  out  1  sticky phase-sequence error (see Optional Feature).

Behaviour:
- "Phase N" is the cycle in which clock_N=1. All registers update on the rising edge that ends that cycle.
- Reset (synchronous, overrides everything): pc=RESET_PC, imem_addr=0, imem_rd=0, ir=0, ir_valid=0, halted=0, phase_err=0, state=IDLE.
- Reset asserted mid-frame aborts the fetch in progress; any returning imem_rdata is ignored.
- States:
  - IDLE: on clock_1 → RUN, and perform the phase-1 fetch action.
  - RUN: normal frames.
  - HALTED: on resume=1 → RESUME.
  - RESUME: on clock_1 → RUN, and perform the fetch.
  - halted=1 exactly in HALTED; it stays 1 in RESUME? No — halted=0 in RESUME.
- RUN frame actions:
  - Phase 1: imem_addr<=pc; imem_rd<=1, so imem_rd is high during phase 2 only.
  - Phase 2: imem_rd<=0. Memory samples the address at this edge; imem_rdata is valid during phase 3.
  - Phase 3: ir<=imem_rdata; ir_valid<=1, so it is high during phase 4 only.
  - Phase 7: if pc_load, pc<=pc_load_value; else pc<=pc+1 modulo 2^ADDR_W (all-ones wraps to 0).
  - Phase 8: if halt_req, → HALTED.
- In IDLE, HALTED and RESUME: no imem_rd, pc frozen, ir held, ir_valid=0; pc_load and halt_req are ignored.
- pc_load then halt_req in the same frame: the load takes effect at phase 7, then the block halts. Resume fetches from the loaded target.
- halt_req and resume both high in HALTED: resume wins. halt_req outside phase 8 has no effect.
- A strobe arriving while no strobe is expected only affects phase_err. Actions are keyed purely on the strobe seen.

Optional Feature:
- Macro: CPU_FETCH_PHASE_CHECK_EN.
- Defined: phase_err is set the cycle after either violation, and clears only on reset.
  - More than one clock_N high in the same cycle.
  - A strobe that is not the successor of the last seen strobe (8→1 wraps). The first strobe after reset is exempt.
- Not defined: checker logic is absent and phase_err is tied 0. The port is always present.

Decomposition:
- Package cpu_pkg:
  - State enum (IDLE, RUN, HALTED, RESUME).
  - Default ADDR_W/DATA_W/OPCODE_W.
  - RESET_PC default.
  - Phase-index constants 1..8.
- Sub-module cpu_phase_checker: last-phase register and sticky error. Instantiated only under CPU_FETCH_PHASE_CHECK_EN.
- Remainder stays flat in cpu_fetch_unit.

Test Plan:
- Reset, memory word at 0x00 = 0x1234, drive phases 1..8:
  - imem_addr=0x00 and imem_rd=1 in phase 2.
  - ir=0x1234 and ir_valid=1 in phase 4 only.
  - opcode=0x1, operand=0x234.
  - pc=0x01 after phase 7.
- pc_load=1, pc_load_value=0x40 in phase 7 → pc=0x40; next frame imem_addr=0x40. pc_load=1 in phase 6 only → ignored, pc increments.
- RESET_PC=0xFF → first fetch address 0xFF; after phase 7, pc=0x00; second fetch address 0x00.
- halt_req=1 in phase 8 → halted=1; no imem_rd over 3 full frames; pc and ir unchanged. Pulse resume in phase 4 → halted=0; fetch at the next clock_1 uses the frozen pc.
- reset pulsed during phase 3 with imem_rdata=0xBEEF → ir=0, ir_valid=0, pc=RESET_PC, state IDLE; 0xBEEF is never latched.
- With CPU_FETCH_PHASE_CHECK_EN, drive clock_1 then clock_3 → phase_err=1 the next cycle and it stays 1 until reset. Drive clock_2 and clock_5 together → phase_err=1. Without the macro, phase_err=0 throughout.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU instruction-fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int CPU_ADDR_W   = 8;
    localparam int CPU_DATA_W   = 16;
    localparam int CPU_OPCODE_W = 4;
    localparam int CPU_RESET_PC = 0;

    // Phase indices as numbered by the clock generator (clock_1 .. clock_8)
    localparam int NUM_PHASES = 8;
    localparam int PH_1 = 1;
    localparam int PH_2 = 2;
    localparam int PH_3 = 3;
    localparam int PH_4 = 4;
    localparam int PH_5 = 5;
    localparam int PH_6 = 6;
    localparam int PH_7 = 7;
    localparam int PH_8 = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        RESUME = 2'd3
    } state_t;

    // One-hot successor of a phase strobe vector; phase 8 wraps to phase 1
    function automatic logic [NUM_PHASES-1:0] next_phase(input logic [NUM_PHASES-1:0] oh);
        return {oh[NUM_PHASES-2:0], oh[NUM_PHASES-1]};
    endfunction

endpackage

// File: rtl/cpu_phase_checker.sv
// Watches the phase strobes and flags multi-hot or out-of-order strobes (sticky).
// Latency: phase_err rises the cycle after the offending strobe.
// Backpressure: none; purely observational.
module cpu_phase_checker
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PHASES-1:0] phases,
    output logic                  phase_err
);

    logic [NUM_PHASES-1:0] last_phase;
    logic                  multi_hot;
    logic                  single_hot;
    logic                  out_of_order;

    // Classify the current strobe vector against the last single strobe seen
    always_comb begin
        multi_hot    = (phases & (phases - 1'b1)) != '0;
        single_hot   = (phases != '0) && !multi_hot;
        // last_phase==0 means no strobe since reset, so the first one is exempt
        out_of_order = single_hot && (last_phase != '0) &&
                       (phases != next_phase(last_phase));
    end

    // Remember the last clean strobe and hold the error until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            last_phase <= '0;
            phase_err  <= 1'b0;
        end else begin
            if (single_hot) begin
                last_phase <= phases;
            end
            if (multi_hot || out_of_order) begin
                phase_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Per-frame instruction fetch: PC, imem read, IR latch and halt/resume control.
// Latency: addr/rd out in phase 2, IR valid in phase 4, PC advances after phase 7.
// Backpressure: halt_req (phase 8) parks the unit; resume re-arms it for the next frame.
// Optional phase-sequence checker is built when CPU_FETCH_PHASE_CHECK_EN is defined.
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int DATA_W   = CPU_DATA_W,
    parameter int OPCODE_W = CPU_OPCODE_W,
    parameter int RESET_PC = CPU_RESET_PC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clock_1,
    input  logic                       clock_2,
    input  logic                       clock_3,
    input  logic                       clock_4,
    input  logic                       clock_5,
    input  logic                       clock_6,
    input  logic                       clock_7,
    input  logic                       clock_8,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic                       imem_rd,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       pc_load,
    input  logic [ADDR_W-1:0]          pc_load_value,
    input  logic                       halt_req,
    input  logic                       resume,
    output logic [ADDR_W-1:0]          pc,
    output logic [DATA_W-1:0]          ir,
    output logic                       ir_valid,
    output logic [OPCODE_W-1:0]        opcode,
    output logic [DATA_W-OPCODE_W-1:0] operand,
    output logic                       halted,
    output logic                       phase_err
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    logic [NUM_PHASES-1:0] phases;
    state_t                state;
    state_t                state_nxt;
    logic                  fetch_go;
    logic                  ir_load;
    logic                  pc_step;

    assign phases = {clock_8, clock_7, clock_6, clock_5,
                     clock_4, clock_3, clock_2, clock_1};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: frames start on clock_1, halt is taken only at phase 8 of a running frame
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (phases[PH_1-1])             state_nxt = RUN;
            RUN:     if (phases[PH_8-1] && halt_req) state_nxt = HALTED;
            HALTED:  if (resume)                     state_nxt = RESUME;
            RESUME:  if (phases[PH_1-1])             state_nxt = RUN;
            default:                                 state_nxt = IDLE;
        endcase
    end

    // Per-phase action enables; IDLE and RESUME launch a fetch on the same clock_1 that enters RUN
    always_comb begin
        fetch_go = phases[PH_1-1] && (state != HALTED);
        ir_load  = phases[PH_3-1] && (state == RUN);
        pc_step  = phases[PH_7-1] && (state == RUN);
        halted   = (state == HALTED);
    end

    // Fetch datapath: address/read strobe, instruction latch and PC update
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= PC_INIT;
            imem_addr <= '0;
            imem_rd   <= 1'b0;
            ir        <= '0;
            ir_valid  <= 1'b0;
        end else begin
            // imem_rd is a single-cycle pulse covering phase 2
            imem_rd  <= fetch_go;
            ir_valid <= ir_load;
            if (fetch_go) begin
                imem_addr <= pc;
            end
            if (ir_load) begin
                ir <= imem_rdata;
            end
            if (pc_step) begin
                pc <= pc_load ? pc_load_value : pc + PC_ONE;
            end
        end
    end

    assign opcode  = ir[DATA_W-1 -: OPCODE_W];
    assign operand = ir[DATA_W-OPCODE_W-1:0];

`ifdef CPU_FETCH_PHASE_CHECK_EN
    cpu_phase_checker u_phase_checker (
        .clk       (clk),
        .reset     (reset),
        .phases    (phases),
        .phase_err (phase_err)
    );
`else
    assign phase_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: frame-level reference model with random branch/halt/resume traffic.
module tb_cpu_fetch_unit;

`ifdef CPU_FETCH_PHASE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ph_vec;
    logic        pc_load;
    logic [7:0]  pc_load_value;
    logic        halt_req;
    logic        resume;
    logic        tie0 = 1'b0;
    logic [7:0]  tie0_8 = 8'h00;

    logic [7:0]  imem_addr, pc;
    logic        imem_rd, ir_valid, halted, phase_err;
    logic [15:0] imem_rdata, ir;
    logic [3:0]  opcode;
    logic [11:0] operand;

    logic [7:0]  imem_addr_ff, pc_ff;
    logic        imem_rd_ff, ir_valid_ff, halted_ff, phase_err_ff;
    logic [15:0] imem_rdata_ff, ir_ff;
    logic [3:0]  opcode_ff;
    logic [11:0] operand_ff;

    logic [15:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference state
    logic [7:0]  m_pc;
    logic [7:0]  m_pc_ff;
    logic [15:0] m_ir;
    bit          m_halted;

    always #5 clk = ~clk;

    cpu_fetch_unit #(.RESET_PC(0)) dut (
        .clk(clk), .reset(reset),
        .clock_1(ph_vec[0]), .clock_2(ph_vec[1]), .clock_3(ph_vec[2]), .clock_4(ph_vec[3]),
        .clock_5(ph_vec[4]), .clock_6(ph_vec[5]), .clock_7(ph_vec[6]), .clock_8(ph_vec[7]),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
        .pc_load(pc_load), .pc_load_value(pc_load_value),
        .halt_req(halt_req), .resume(resume),
        .pc(pc), .ir(ir), .ir_valid(ir_valid), .opcode(opcode), .operand(operand),
        .halted(halted), .phase_err(phase_err)
    );

    cpu_fetch_unit #(.RESET_PC(8'hFF)) dut_ff (
        .clk(clk), .reset(reset),
        .clock_1(ph_vec[0]), .clock_2(ph_vec[1]), .clock_3(ph_vec[2]), .clock_4(ph_vec[3]),
        .clock_5(ph_vec[4]), .clock_6(ph_vec[5]), .clock_7(ph_vec[6]), .clock_8(ph_vec[7]),
        .imem_addr(imem_addr_ff), .imem_rd(imem_rd_ff), .imem_rdata(imem_rdata_ff),
        .pc_load(tie0), .pc_load_value(tie0_8),
        .halt_req(tie0), .resume(tie0),
        .pc(pc_ff), .ir(ir_ff), .ir_valid(ir_valid_ff), .opcode(opcode_ff), .operand(operand_ff),
        .halted(halted_ff), .phase_err(phase_err_ff)
    );

    // Synchronous instruction memories: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (imem_rd)    imem_rdata    <= mem[imem_addr];
        if (imem_rd_ff) imem_rdata_ff <= mem[imem_addr_ff];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One 8-phase frame. ld_ph/hr_ph/rs_ph give the phase at which pc_load,
    // halt_req and resume are raised (0 = never). halt_req is also raised
    // together with resume to show resume wins in HALTED.
    task automatic frame(input int ld_ph, input logic [7:0] ldv, input int hr_ph, input int rs_ph);
        bit          active;
        bit          was_halted;
        logic [15:0] exp_ir;
        active     = !m_halted;
        was_halted = m_halted;
        exp_ir     = active ? mem[m_pc] : m_ir;
        for (int p = 1; p <= 8; p++) begin
            @(negedge clk);
            ph_vec        = 8'h01 << (p - 1);
            pc_load       = (p == ld_ph);
            pc_load_value = ldv;
            halt_req      = (p == hr_ph) || (p == rs_ph);
            resume        = (p == rs_ph);
            case (p)
                1: check("halted_ph1", halted, m_halted);
                2: begin
                    check("imem_rd_ph2", imem_rd, active);
                    if (active) check("imem_addr_ph2", imem_addr, m_pc);
                    check("ff_imem_rd_ph2", imem_rd_ff, 1'b1);
                    check("ff_imem_addr_ph2", imem_addr_ff, m_pc_ff);
                end
                3: begin
                    check("imem_rd_ph3", imem_rd, 1'b0);
                    check("ir_valid_ph3", ir_valid, 1'b0);
                end
                4: begin
                    check("ir_valid_ph4", ir_valid, active);
                    check("ir_ph4", ir, exp_ir);
                    check("opcode_ph4", opcode, exp_ir[15:12]);
                    check("operand_ph4", operand, exp_ir[11:0]);
                end
                5: check("ir_valid_ph5", ir_valid, 1'b0);
                7: check("pc_ph7", pc, m_pc);
                8: begin
                    if (active) begin
                        m_pc = (ld_ph == 7) ? ldv : m_pc + 8'd1;
                        m_ir = exp_ir;
                    end
                    m_pc_ff = m_pc_ff + 8'd1;
                    check("pc_ph8", pc, m_pc);
                    check("ff_pc_ph8", pc_ff, m_pc_ff);
                    check("phase_err_ph8", phase_err, 1'b0);
                end
                default: ;
            endcase
            if (was_halted && rs_ph != 0 && p == rs_ph + 1)
                check("halted_after_resume", halted, 1'b0);
        end
        if (active && hr_ph == 8) m_halted = 1'b1;
        if (was_halted && rs_ph != 0) m_halted = 1'b0;
    endtask

    initial begin
        int ld_ph, hr_ph, rs_ph;
        reset = 1'b1; ph_vec = '0; pc_load = 0; pc_load_value = '0; halt_req = 0; resume = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234;
        m_pc = 8'h00; m_pc_ff = 8'hFF; m_ir = 16'h0000; m_halted = 0;

        repeat (2) @(negedge clk);
        check("rst_pc", pc, 8'h00);
        check("rst_pc_ff", pc_ff, 8'hFF);
        check("rst_ir", ir, 16'h0000);
        check("rst_ir_valid", ir_valid, 1'b0);
        check("rst_imem_rd", imem_rd, 1'b0);
        check("rst_imem_addr", imem_addr, 8'h00);
        check("rst_halted", halted, 1'b0);
        check("rst_phase_err", phase_err, 1'b0);
        reset = 1'b0;

        // Directed frames: first fetch, branch, ignored load, halt/resume, load+halt
        frame(0, 8'h00, 0, 0);
        frame(7, 8'h40, 0, 0);
        frame(6, 8'h99, 0, 0);
        frame(0, 8'h00, 8, 0);
        frame(7, 8'h10, 8, 0);
        frame(0, 8'h00, 0, 0);
        frame(0, 8'h00, 0, 4);
        frame(0, 8'h00, 0, 0);
        frame(7, 8'h80, 8, 0);
        frame(0, 8'h00, 0, 3);
        frame(0, 8'h00, 5, 0);

        // Randomized traffic
        for (int f = 0; f < 40; f++) begin
            int r;
            r     = $urandom_range(0, 2);
            ld_ph = (r == 0) ? 0 : (r == 1) ? 6 : 7;
            r     = $urandom_range(0, 5);
            hr_ph = (r == 0) ? 8 : (r == 1) ? 5 : 0;
            rs_ph = (m_halted && $urandom_range(0, 1) == 1) ? $urandom_range(2, 6) : 0;
            frame(ld_ph, 8'($urandom), hr_ph, rs_ph);
        end
        if (m_halted) frame(0, 8'h00, 0, 3);

        // Reset during phase 3 of a fetch whose data is 0xBEEF
        mem[m_pc] = 16'hBEEF;
        @(negedge clk); ph_vec = 8'h01; pc_load = 0; halt_req = 0; resume = 0;
        @(negedge clk); ph_vec = 8'h02;
        check("abort_addr", imem_addr, m_pc);
        @(negedge clk); ph_vec = 8'h04; reset = 1'b1;
        @(negedge clk); ph_vec = 8'h08; reset = 1'b0;
        check("abort_ir", ir, 16'h0000);
        check("abort_ir_valid", ir_valid, 1'b0);
        check("abort_pc", pc, 8'h00);
        check("abort_pc_ff", pc_ff, 8'hFF);
        check("abort_halted", halted, 1'b0);
        for (int p = 5; p <= 8; p++) begin
            @(negedge clk); ph_vec = 8'h01 << (p - 1);
            check("idle_ir_valid", ir_valid, 1'b0);
        end
        check("idle_pc", pc, 8'h00);
        check("idle_ir", ir, 16'h0000);
        m_pc = 8'h00; m_pc_ff = 8'hFF; m_ir = 16'h0000; m_halted = 0;
        frame(0, 8'h00, 0, 0);
        frame(7, 8'h22, 0, 0);

        // Phase-sequence checker: skipped phase, then multi-hot strobes
        @(negedge clk); ph_vec = 8'h01;
        @(negedge clk); ph_vec = 8'h04;
        @(negedge clk); ph_vec = 8'h00;
        check("perr_skip", phase_err, CHK_EN);
        repeat (5) @(negedge clk);
        check("perr_sticky", phase_err, CHK_EN);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("perr_reset", phase_err, 1'b0);
        ph_vec = 8'h12;
        @(negedge clk); ph_vec = 8'h00;
        check("perr_multi", phase_err, CHK_EN);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
